muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative multiply/divide responder behind the execute stage's multicycle request
//  (is_multdiv/multicycle_type/a/b -> hi/lo/ok). Computes HI:LO for MULT(U)/MADD(U)/MSUB(U)/DIV(U).
//  Execute stalls while ok=0. Execute does the MADD/MSUB accumulation itself; this unit returns only the raw product.
// PARAMETERS
//  DATA_WIDTH    32  operand width; product is 2*DATA_WIDTH
//  DIV_BITS      1   quotient bits retired per divide cycle (1 or 2); DIV_CYC = DATA_WIDTH/DIV_BITS
// PORTS
//  clk             in   1     clock
//  resetn          in   1     synchronous active-low reset
//  a               in   32    operand A (dividend / multiplicand)
//  b               in   32    operand B (divisor / multiplier)
//  is_multdiv      in   1     request valid; held high by E until ok seen with hold=0
//  multicycle_type in   4     multicycle_type_t opcode
//  hold            in   1     E stage stalled by another source; keep result
//  flush           in   1     kill in-flight op
//  hi              out  32    MULT: product[63:32]; DIV: remainder
//  lo              out  32    MULT: product[31:0];  DIV: quotient
//  ok              out  1     result valid / no stall needed
// BEHAVIOUR
//  - Reset (resetn=0 at posedge): state=IDLE, hi=lo=0, counters=0. ok=1 while in IDLE with is_multdiv=0.
//  - ok is combinational: ok = ~is_multdiv | (state==DONE) | flush.
//  - States: IDLE, MUL, DIV, DONE.
//  - IDLE: on is_multdiv & ~flush, latch a, b, and type.
//    MULT* -> MUL; DIV* -> DIV with cnt=0.
//    Signed ops take magnitudes; record sign_q = a[31]^b[31] and sign_r = a[31].
//  - MUL: 1 cycle. Register four 16x16 unsigned partial products.
//    Next cycle -> DONE; hi:lo = sum, sign-corrected (two's-complement negate if signed and sign_q).
//    Latency: request seen in cycle 0, ok=1 in cycle 2.
//  - DIV: restoring divider, DIV_BITS per cycle for DIV_CYC cycles; cnt wraps at DIV_CYC-1, then -> DONE.
//    Signs are fixed on the transition into DONE.
//    DIV_BITS=1: ok=1 in cycle DIV_CYC+1 (33).
//  - DONE: hi/lo stable, ok=1.
//    hold=1 -> stay in DONE.
//    hold=0 -> IDLE next cycle, without restarting on the still-high is_multdiv.
//    A back-to-back request is accepted from IDLE one cycle later.
//  - hi/lo change only on entry to DONE; they keep the last result otherwise.
//  - flush (any state): -> IDLE next cycle, hi/lo unchanged, ok=1 that cycle.
//    flush wins over a simultaneous new request.
//  - is_multdiv dropping in MUL/DIV without flush: abort to IDLE, hi/lo unchanged.
//  - Divide by zero: no exception. Unsigned: lo=0xFFFFFFFF, hi=a.
//    Signed: magnitude result above, then sign rules applied.
//  - Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
//  - Sign rules: quotient negative iff sign_q & quotient!=0; remainder takes dividend sign.
//  - Reset mid-operation: abort to IDLE with hi/lo cleared; no stale DONE afterwards.
// STRUCTURE
//  - execute_pkg already holds multicycle_type_t (M_MULT, M_MULTU, M_DIV, M_DIVU, M_MADD, M_MADDU, M_MSUB, M_MSUBU).
//    Add to it: muldiv_state_t and localparams MUL_CYC=2, DIV_CYC.
//  - One sub-module: muldiv_divider. It is the unsigned restoring core:
//    start, dividend, divisor -> quotient, remainder, done; DIV_BITS parameter.
//    Sign handling and the FSM stay in muldiv_unit.
// TESTING
//  - MULT a=0xFFFFFFFE(-2), b=3: ok low 2 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//  - MULTU a=0xFFFFFFFF, b=0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001 at cycle 2.
//  - DIV a=-7 (0xFFFFFFF9), b=2: ok at cycle 33, lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1).
//    DIVU a=7, b=0: lo=0xFFFFFFFF, hi=7.
//  - DIV a=0x80000000, b=0xFFFFFFFF: lo=0x80000000, hi=0.
//  - hold=1 for 5 cycles after DONE: hi/lo/ok stable.
//    Release hold, then issue a back-to-back MULTU 6*7: new result lo=42, no double-issue.
//  - flush at DIV cycle 10, then new MULTU 2*3: ok=1 in the flush cycle; next result lo=6 at cycle 2.
//    Also resetn=0 mid-DIV: hi=lo=0, ok=1 with is_multdiv=0.

Source files
------------

// File: rtl/execute_pkg.sv
// Shared execute-stage types: multicycle opcodes plus the mul/div unit state and cycle counts.
// Opcode classification helpers keep the decode in one place.
package execute_pkg;

    typedef enum logic [3:0] {
        M_NONE  = 4'd0,
        M_MULT  = 4'd1,
        M_MULTU = 4'd2,
        M_DIV   = 4'd3,
        M_DIVU  = 4'd4,
        M_MADD  = 4'd5,
        M_MADDU = 4'd6,
        M_MSUB  = 4'd7,
        M_MSUBU = 4'd8
    } multicycle_type_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } muldiv_state_t;

    localparam int MD_DATA_WIDTH = 32;
    localparam int MD_DIV_BITS   = 1;
    localparam int MUL_CYC       = 2;
    localparam int DIV_CYC       = MD_DATA_WIDTH / MD_DIV_BITS;

    function automatic logic is_signed_op(input multicycle_type_t t);
        return (t == M_MULT) || (t == M_DIV) || (t == M_MADD) || (t == M_MSUB);
    endfunction

    function automatic logic is_div_op(input multicycle_type_t t);
        return (t == M_DIV) || (t == M_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Unsigned restoring divider core, DIV_BITS quotient bits per run cycle, DW/DIV_BITS cycles.
// done and the outputs are combinational for the final step so the caller can capture them that edge.
module muldiv_divider
    import execute_pkg::*;
#(
    parameter int DW       = MD_DATA_WIDTH,
    parameter int DIV_BITS = MD_DIV_BITS
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic          run,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic [DW-1:0] quotient,
    output logic [DW-1:0] remainder,
    output logic          done
);

    localparam int CYC = DW / DIV_BITS;
    localparam int CW  = $clog2(CYC);
    localparam logic [CW-1:0] LAST = CW'(CYC - 1);

    logic [DW-1:0] rem_q, rem_d;
    logic [DW-1:0] quo_q, quo_d;
    logic [DW-1:0] dvs_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW:0]   trial;

    // quo holds the unconsumed dividend bits on the left and the quotient filling in on the right
    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        trial = '0;
        for (int i = 0; i < DIV_BITS; i++) begin
            trial = {rem_d, quo_d[DW-1]};
            quo_d = {quo_d[DW-2:0], 1'b0};
            if (trial >= {1'b0, dvs_q}) begin
                trial    = trial - {1'b0, dvs_q};
                quo_d[0] = 1'b1;
            end
            rem_d = trial[DW-1:0];
        end
    end

    assign done      = run && (cnt_q == LAST);
    assign cnt_d     = done ? '0 : cnt_q + 1'b1;
    assign quotient  = quo_d;
    assign remainder = rem_d;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
            cnt_q <= '0;
        end else if (run) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MADD/MSUB/DIV responder: mul ok at cycle 2, div ok at cycle DIV_CYC+1.
// ok low stalls execute; hold parks the result in DONE, flush or a dropped request aborts to IDLE.
module muldiv_unit
    import execute_pkg::*;
#(
    parameter int DATA_WIDTH = MD_DATA_WIDTH,
    parameter int DIV_BITS   = MD_DIV_BITS
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  is_multdiv,
    input  logic [3:0]            multicycle_type,
    input  logic                  hold,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo,
    output logic                  ok
);

    localparam int DW = DATA_WIDTH;
    localparam int HW = DATA_WIDTH / 2;
    localparam int PW = 2 * DATA_WIDTH;

    multicycle_type_t op;
    muldiv_state_t    state_q, state_d;
    logic             op_signed, op_div, accept;
    logic [DW-1:0]    a_mag, b_mag;
    logic [DW-1:0]    a_lo, a_hi, b_lo, b_hi;
    logic [DW-1:0]    pp_q [4];
    logic             signed_op_q, sign_q, sign_r_q;
    logic [DW-1:0]    hi_q, hi_d, lo_q, lo_d;
    logic [PW-1:0]    prod, mul_res;
    logic [DW-1:0]    div_quo, div_rem, quo_fix, rem_fix;
    logic             div_run, div_done;

    assign op        = multicycle_type_t'(multicycle_type);
    assign op_signed = is_signed_op(op);
    assign op_div    = is_div_op(op);
    assign accept    = (state_q == S_IDLE) && is_multdiv && !flush;

    assign a_mag = (op_signed && a[DW-1]) ? -a : a;
    assign b_mag = (op_signed && b[DW-1]) ? -b : b;
    assign a_lo  = {{HW{1'b0}}, a_mag[HW-1:0]};
    assign a_hi  = {{HW{1'b0}}, a_mag[DW-1:HW]};
    assign b_lo  = {{HW{1'b0}}, b_mag[HW-1:0]};
    assign b_hi  = {{HW{1'b0}}, b_mag[DW-1:HW]};

    // Partial products are registered on acceptance, so the MUL cycle only sums and fixes the sign
    assign prod = PW'(pp_q[0])
                + (PW'(pp_q[1]) << HW)
                + (PW'(pp_q[2]) << HW)
                + (PW'(pp_q[3]) << DW);
    assign mul_res = (signed_op_q && sign_q) ? -prod : prod;

    assign div_run = (state_q == S_DIV) && is_multdiv && !flush;
    assign quo_fix = (signed_op_q && sign_q)   ? -div_quo : div_quo;
    assign rem_fix = (signed_op_q && sign_r_q) ? -div_rem : div_rem;

    muldiv_divider #(
        .DW       (DW),
        .DIV_BITS (DIV_BITS)
    ) u_divider (
        .clk       (clk),
        .resetn    (resetn),
        .start     (accept && op_div),
        .run       (div_run),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (div_quo),
        .remainder (div_rem),
        .done      (div_done)
    );

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = op_div ? S_DIV : S_MUL;
            end
            S_MUL: begin
                if (flush || !is_multdiv) begin
                    state_d = S_IDLE;
                end else begin
                    state_d      = S_DONE;
                    {hi_d, lo_d} = mul_res;
                end
            end
            S_DIV: begin
                if (flush || !is_multdiv) begin
                    state_d = S_IDLE;
                end else if (div_done) begin
                    state_d = S_DONE;
                    hi_d    = rem_fix;
                    lo_d    = quo_fix;
                end
            end
            // Always pass through IDLE so the still-high request of this op cannot restart it
            S_DONE: begin
                if (flush || !hold) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            hi_q        <= '0;
            lo_q        <= '0;
            signed_op_q <= 1'b0;
            sign_q      <= 1'b0;
            sign_r_q    <= 1'b0;
            for (int i = 0; i < 4; i++) pp_q[i] <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            if (accept) begin
                signed_op_q <= op_signed;
                sign_q      <= a[DW-1] ^ b[DW-1];
                sign_r_q    <= a[DW-1];
                pp_q[0]     <= a_lo * b_lo;
                pp_q[1]     <= a_hi * b_lo;
                pp_q[2]     <= a_lo * b_hi;
                pp_q[3]     <= a_hi * b_hi;
            end
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;
    assign ok = !is_multdiv || (state_q == S_DONE) || flush;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    import execute_pkg::*;

    logic        clk;
    logic        resetn;
    logic [31:0] a_in, b_in;
    logic        is_md;
    logic [3:0]  mc_type;
    logic        hold, flush;
    logic [31:0] hi, lo;
    logic        ok;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_hi  = '0;
    logic [31:0] last_lo  = '0;

    typedef struct {
        logic [3:0]  t;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;
    vec_t vecs[$];

    muldiv_unit dut (
        .clk             (clk),
        .resetn          (resetn),
        .a               (a_in),
        .b               (b_in),
        .is_multdiv      (is_md),
        .multicycle_type (mc_type),
        .hold            (hold),
        .flush           (flush),
        .hi              (hi),
        .lo              (lo),
        .ok              (ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [3:0] t);
        return (t == M_DIV || t == M_DIVU) ? 33 : 2;
    endfunction

    // Reference: plain 64-bit products and language-level division plus the documented special cases
    function automatic void model(input logic [3:0] t, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] h, output logic [31:0] l);
        logic [63:0] p;
        int          sx, sy;
        sx = x;
        sy = y;
        p  = '0;
        h  = '0;
        l  = '0;
        case (t)
            M_MULT, M_MADD, M_MSUB: begin
                p = longint'(sx) * longint'(sy);
                {h, l} = p;
            end
            M_MULTU, M_MADDU, M_MSUBU: begin
                p = {32'b0, x} * {32'b0, y};
                {h, l} = p;
            end
            M_DIVU: begin
                if (y == 0) begin
                    l = 32'hFFFF_FFFF;
                    h = x;
                end else begin
                    l = x / y;
                    h = x % y;
                end
            end
            M_DIV: begin
                if (y == 0) begin
                    l = x[31] ? 32'h1 : 32'hFFFF_FFFF;
                    h = x;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    l = 32'h8000_0000;
                    h = 32'h0;
                end else begin
                    l = sx / sy;
                    h = sx % sy;
                end
            end
            default: ;
        endcase
    endfunction

    task automatic run_op(input logic [3:0] t, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el, input string name);
        int cyc;
        mc_type = t;
        a_in    = x;
        b_in    = y;
        is_md   = 1'b1;
        cyc     = 0;
        #1;
        while (!ok && cyc < 100) begin
            tick();
            cyc++;
        end
        chk({name, " latency"}, 64'(cyc), 64'(exp_lat(t)));
        chk({name, " hi"}, {32'b0, hi}, {32'b0, eh});
        chk({name, " lo"}, {32'b0, lo}, {32'b0, el});
        last_hi = eh;
        last_lo = el;
    endtask

    task automatic finish_op();
        tick();
        is_md = 1'b0;
    endtask

    task automatic add_vec(input logic [3:0] t, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] h, input logic [31:0] l);
        vec_t v;
        v.t  = t;
        v.a  = x;
        v.b  = y;
        v.hi = h;
        v.lo = l;
        vecs.push_back(v);
    endtask

    initial begin
        logic [3:0]  types[8];
        logic [3:0]  rt;
        logic [31:0] ra, rb, eh, el;

        types = '{M_MULT, M_MULTU, M_DIV, M_DIVU, M_MADD, M_MADDU, M_MSUB, M_MSUBU};

        add_vec(M_MULT,  32'hFFFF_FFFE, 32'h3,          32'hFFFF_FFFF, 32'hFFFF_FFFA);
        add_vec(M_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        add_vec(M_DIV,   32'hFFFF_FFF9, 32'h2,          32'hFFFF_FFFF, 32'hFFFF_FFFD);
        add_vec(M_DIVU,  32'h7,         32'h0,          32'h7,         32'hFFFF_FFFF);
        add_vec(M_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000);
        add_vec(M_MADD,  32'h0001_0000, 32'h0001_0000, 32'h1,         32'h0);
        add_vec(M_MSUBU, 32'h1234_5678, 32'h100,        32'h12,        32'h3456_7800);
        add_vec(M_DIVU,  32'd100,       32'd7,          32'd2,         32'd14);
        add_vec(M_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
        add_vec(M_DIV,   32'hFFFF_FFF8, 32'h0,          32'hFFFF_FFF8, 32'h1);
        add_vec(M_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
        add_vec(M_MULTU, 32'h0,         32'd5,          32'h0,         32'h0);

        resetn  = 1'b0;
        a_in    = '0;
        b_in    = '0;
        is_md   = 1'b0;
        mc_type = M_NONE;
        hold    = 1'b0;
        flush   = 1'b0;
        tick();
        tick();
        chk("reset hi", {32'b0, hi}, 64'h0);
        chk("reset lo", {32'b0, lo}, 64'h0);
        chk("reset ok", {63'b0, ok}, 64'h1);
        resetn = 1'b1;
        tick();

        foreach (vecs[i]) begin
            run_op(vecs[i].t, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i));
            finish_op();
        end

        // hold keeps the result, then a back-to-back op must not reissue the old one
        hold = 1'b1;
        run_op(M_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, "hold op");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("hold ok c%0d", i), {63'b0, ok}, 64'h1);
            chk($sformatf("hold lo c%0d", i), {32'b0, lo}, 64'd15);
        end
        chk("hold hi", {32'b0, hi}, 64'h0);
        hold = 1'b0;
        tick();
        run_op(M_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, "b2b multu");
        finish_op();

        // flush at DIV cycle 10
        mc_type = M_DIV;
        a_in    = 32'd1000;
        b_in    = 32'd3;
        is_md   = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("div mid ok", {63'b0, ok}, 64'h0);
        flush = 1'b1;
        #1;
        chk("flush cycle ok", {63'b0, ok}, 64'h1);
        tick();
        flush = 1'b0;
        is_md = 1'b0;
        #1;
        chk("flush hi kept", {32'b0, hi}, {32'b0, last_hi});
        chk("flush lo kept", {32'b0, lo}, {32'b0, last_lo});
        run_op(M_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, "post flush");
        finish_op();

        // flush beats a simultaneous new request
        mc_type = M_MULTU;
        a_in    = 32'd4;
        b_in    = 32'd5;
        is_md   = 1'b1;
        flush   = 1'b1;
        tick();
        flush   = 1'b0;
        run_op(M_MULTU, 32'd4, 32'd5, 32'd0, 32'd20, "flush vs req");
        finish_op();

        // request dropped mid-divide
        mc_type = M_DIVU;
        a_in    = 32'd77;
        b_in    = 32'd5;
        is_md   = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        is_md = 1'b0;
        tick();
        tick();
        chk("abort hi kept", {32'b0, hi}, {32'b0, last_hi});
        chk("abort lo kept", {32'b0, lo}, {32'b0, last_lo});
        run_op(M_MULT, 32'hFFFF_FFFF, 32'd9, 32'hFFFF_FFFF, 32'hFFFF_FFF7, "post abort");
        finish_op();

        // reset mid-divide
        mc_type = M_DIVU;
        a_in    = 32'd1000;
        b_in    = 32'd3;
        is_md   = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        is_md  = 1'b0;
        #1;
        chk("mid reset ok", {63'b0, ok}, 64'h1);
        for (int i = 0; i < 3; i++) tick();
        chk("mid reset hi", {32'b0, hi}, 64'h0);
        chk("mid reset lo", {32'b0, lo}, 64'h0);
        run_op(M_MULTU, 32'd9, 32'd9, 32'd0, 32'd81, "post reset");
        finish_op();

        // randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            rt = types[$urandom_range(0, 7)];
            case ($urandom_range(0, 3))
                0:       begin ra = $urandom_range(0, 1000); rb = $urandom_range(0, 50); end
                1:       begin ra = $urandom; rb = $urandom_range(0, 3) == 0 ? 32'h0 : $urandom; end
                2:       begin ra = -$urandom_range(1, 5000); rb = $urandom_range(1, 100); end
                default: begin ra = $urandom; rb = $urandom; end
            endcase
            model(rt, ra, rb, eh, el);
            run_op(rt, ra, rb, eh, el, $sformatf("rand%0d t%0d %h %h", i, rt, ra, rb));
            finish_op();
        end

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
